apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  APB4 requester (initiator) driving G_NUM_SLAVES completers over a shared bus with one-hot psel.
//  Accepts single read/write commands on a valid/ready port and runs one APB transfer per command.
//  Returns the selected completer's prdata/pslverr on a valid/ready response port.
//  Adds a pready timeout and decode-error handling. Sits between a local bus/CSR engine and a bank of APB register blocks.
// PARAMETERS
//  G_REGWIDTH    32  data width (multiple of 8)
//  G_ADDR_WIDTH  7   paddr width
//  G_NUM_SLAVES  8   number of completers (>=1); SW = max(1,$clog2(G_NUM_SLAVES))
//  G_TIMEOUT     16  max ACCESS cycles waiting for pready (>=2)
// PORTS
//  clk            in   1              clock; all logic on rising edge
//  rst            in   1              synchronous, active-high reset
//  cmd_valid      in   1              command valid
//  cmd_ready      out  1              command accepted when valid&ready
//  cmd_write      in   1              1=write, 0=read
//  cmd_sel        in   SW             target completer index
//  cmd_addr       in   G_ADDR_WIDTH   address
//  cmd_wdata      in   G_REGWIDTH     write data
//  cmd_strb       in   G_REGWIDTH/8   write strobes
//  cmd_prot       in   3              pprot value
//  rsp_valid      out  1              response valid
//  rsp_ready      in   1              response consumed when valid&ready
//  rsp_rdata      out  G_REGWIDTH     read data (0 for writes/errors)
//  rsp_err        out  1              pslverr, timeout or decode error
//  rsp_timeout    out  1              error was a pready timeout
//  m_apb_psel     out  G_NUM_SLAVES   one-hot select
//  m_apb_penable  out  1              access phase
//  m_apb_pwrite   out  1
//  m_apb_pprot    out  3
//  m_apb_paddr    out  G_ADDR_WIDTH
//  m_apb_pwdata   out  G_REGWIDTH
//  m_apb_pstrb    out  G_REGWIDTH/8
//  m_apb_pready   in   G_NUM_SLAVES          per-completer pready
//  m_apb_prdata   in   G_NUM_SLAVES*G_REGWIDTH  completer i at [i*G_REGWIDTH +: G_REGWIDTH]
//  m_apb_pslverr  in   G_NUM_SLAVES          per-completer pslverr
// BEHAVIOUR
//  - Reset: state IDLE. cmd_ready=1. rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite = 0. paddr, pwdata, pstrb, pprot, rsp_rdata = 0. Timeout counter 0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. cmd_ready=1 only in IDLE. One outstanding command; no pipelining.
//  - IDLE: on cmd_valid, latch the command.
//    - cmd_sel < G_NUM_SLAVES: go to SETUP.
//    - Otherwise: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
//  - SETUP (1 cycle): psel[sel]=1, penable=0, bus fields driven from the latched command.
//    - pstrb = cmd_strb on writes; forced 0 on reads.
//  - ACCESS: psel[sel]=1, penable=1. paddr, pwdata, pwrite, pstrb and pprot held stable.
//  - Only pready[sel] and pslverr[sel] are sampled. Other completers' inputs are ignored.
//  - pready[sel]=1: capture rsp_rdata (prdata slice on reads, 0 on writes) and rsp_err=pslverr[sel]; go to RESP.
//    - psel and penable are 0 in the next cycle (no back-to-back hold).
//  - Timeout: counter counts ACCESS cycles with pready[sel]=0. If the G_TIMEOUT-th ACCESS cycle also has pready=0, abort:
//    - psel and penable drop next cycle.
//    - RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    - pready arriving on the G_TIMEOUT-th cycle completes normally (no timeout).
//  - RESP: rsp_valid=1 with stable rsp_* until rsp_ready; then IDLE. Back-pressure is unlimited.
//  - Latency (zero-wait completer): accept at T; SETUP T+1; ACCESS T+2; rsp_valid T+3; next cmd_ready T+4 if rsp_ready at T+3.
//  - Between transfers psel=0 and penable=0. Address/data/pprot outputs keep their last value.
//  - rst mid-transfer: next cycle state IDLE, all outputs at reset values. Any pending response is discarded.
// TESTING
//  - Write sel=3 addr=0x10 wdata=0xDEADBEEF strb=0xF, zero-wait -> psel=0x08 for 2 cycles, penable in cycle 2; rsp_valid 3 cycles after accept; err=0.
//  - Read sel=5 addr=0x04, prdata slice 5=0x12345678, pready after 3 waits -> rsp_rdata=0x12345678; pstrb=0 on bus; pready[0..4,6,7] toggling has no effect.
//  - Read sel=2, pslverr[2]=1 with pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0x12345678 captured (err flags it).
//  - Read sel=1, pready[1] never asserted, G_TIMEOUT=16 -> exactly 16 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  - G_NUM_SLAVES=6, cmd_sel=7 -> psel stays 0, rsp_valid next cycle with rsp_err=1; rsp_ready held low 5 cycles -> response held stable.
//  - rst asserted during ACCESS -> next cycle psel=0, penable=0, cmd_ready=1, rsp_valid=0; new command then completes normally.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// APB4 bus bundle between one requester and G_NUM_SLAVES completers (one-hot psel, per-completer return paths).
// Latency: none, wires only.
// Backpressure: completers stall the requester through their own pready bit.
// Ports: master drives psel/penable/pwrite/pprot/paddr/pwdata/pstrb and receives pready/prdata/pslverr;
//        slave is the mirror view. prdata packs completer i at [i*G_REGWIDTH +: G_REGWIDTH].
interface apb_cmd_master_if #(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 7,
    parameter int G_NUM_SLAVES = 8
);
    logic [G_NUM_SLAVES-1:0]            psel;
    logic                               penable;
    logic                               pwrite;
    logic [2:0]                         pprot;
    logic [G_ADDR_WIDTH-1:0]            paddr;
    logic [G_REGWIDTH-1:0]              pwdata;
    logic [G_REGWIDTH/8-1:0]            pstrb;
    logic [G_NUM_SLAVES-1:0]            pready;
    logic [G_NUM_SLAVES*G_REGWIDTH-1:0] prdata;
    logic [G_NUM_SLAVES-1:0]            pslverr;

    modport master (
        output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 requester: runs one APB transfer per accepted command, with pready timeout and select decode error.
// Latency: zero-wait completer gives rsp_valid 3 cycles after accept; decode error gives rsp_valid 1 cycle after.
// Backpressure: cmd_ready only in IDLE (one outstanding command); response held stable until rsp_ready, unbounded.
// Ports: clk/rst (sync, active-high); cmd_* valid/ready command in; rsp_* valid/ready response out;
//        m_apb master modport to the shared completer bus.
module apb_cmd_master #(
    parameter int  G_REGWIDTH   = 32,
    parameter int  G_ADDR_WIDTH = 7,
    parameter int  G_NUM_SLAVES = 8,
    parameter int  G_TIMEOUT    = 16,
    localparam int SW           = (G_NUM_SLAVES > 1) ? $clog2(G_NUM_SLAVES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [SW-1:0]             cmd_sel,
    input  logic [G_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [G_REGWIDTH-1:0]     cmd_wdata,
    input  logic [G_REGWIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [G_REGWIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    apb_cmd_master_if.master          m_apb
);
    localparam int SB = G_REGWIDTH / 8;
    // Counter only needs to reach G_TIMEOUT-1: the abort decision is taken on that value.
    localparam int CW = $clog2(G_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(G_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                    state_q,       state_d;
    logic                      cmd_ready_q,   cmd_ready_d;
    logic [SW-1:0]             sel_q,         sel_d;
    logic [CW-1:0]             tmo_cnt_q,     tmo_cnt_d;
    logic [G_NUM_SLAVES-1:0]   psel_q,        psel_d;
    logic                      penable_q,     penable_d;
    logic                      pwrite_q,      pwrite_d;
    logic [2:0]                pprot_q,       pprot_d;
    logic [G_ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
    logic [G_REGWIDTH-1:0]     pwdata_q,      pwdata_d;
    logic [SB-1:0]             pstrb_q,       pstrb_d;
    logic                      rsp_valid_q,   rsp_valid_d;
    logic [G_REGWIDTH-1:0]     rsp_rdata_q,   rsp_rdata_d;
    logic                      rsp_err_q,     rsp_err_d;
    logic                      rsp_timeout_q, rsp_timeout_d;

    // Only the addressed completer's return path is looked at.
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [G_REGWIDTH-1:0] prdata_sel;

    assign pready_sel  = m_apb.pready[sel_q];
    assign pslverr_sel = m_apb.pslverr[sel_q];
    assign prdata_sel  = m_apb.prdata[int'(sel_q) * G_REGWIDTH +: G_REGWIDTH];

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        tmo_cnt_d     = tmo_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pprot_d       = pprot_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (int'(cmd_sel) < G_NUM_SLAVES) begin
                        state_d   = S_SETUP;
                        sel_d     = cmd_sel;
                        tmo_cnt_d = '0;
                        for (int i = 0; i < G_NUM_SLAVES; i++) begin
                            psel_d[i] = (int'(cmd_sel) == i);
                        end
                        penable_d = 1'b0;
                        pwrite_d  = cmd_write;
                        pprot_d   = cmd_prot;
                        paddr_d   = cmd_addr;
                        pwdata_d  = cmd_wdata;
                        pstrb_d   = cmd_write ? cmd_strb : '0;
                    end else begin
                        // Unmapped target: answer straight away, bus untouched.
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (pready_sel) begin
                    state_d       = S_RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr_sel;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_sel;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // This was the last allowed ACCESS cycle without pready.
                    state_d       = S_RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            sel_q         <= '0;
            tmo_cnt_q     <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pprot_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            sel_q         <= sel_d;
            tmo_cnt_q     <= tmo_cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pprot_q       <= pprot_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_apb.psel    = psel_q;
    assign m_apb.penable = penable_q;
    assign m_apb.pwrite  = pwrite_q;
    assign m_apb.pprot   = pprot_q;
    assign m_apb.paddr   = paddr_q;
    assign m_apb.pwdata  = pwdata_q;
    assign m_apb.pstrb   = pstrb_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master with 6 completers (so select values 6 and 7 are unmapped) and a 16-cycle timeout.
// Latency: each command is followed until its response is consumed.
// Backpressure: rsp_ready is held low for a per-command number of cycles.
module tb_apb_cmd_master;
    localparam int NS  = 6;
    localparam int RW  = 32;
    localparam int AW  = 7;
    localparam int TMO = 16;

    typedef struct {
        logic        wr;
        logic [2:0]  sel;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;   // pready-low ACCESS cycles before pready (>= TMO: never)
        logic        slverr;
        logic [31:0] prd;
        int          rdly;    // cycles rsp_ready is held low
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tmo;
        int          e_acc;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          acc;
        int          setup;
        int          lat;
        int          bad;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_sel;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    apb_cmd_master_if #(.G_REGWIDTH(RW), .G_ADDR_WIDTH(AW), .G_NUM_SLAVES(NS)) apb ();

    apb_cmd_master #(
        .G_REGWIDTH(RW), .G_ADDR_WIDTH(AW), .G_NUM_SLAVES(NS), .G_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_apb(apb.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Completers: the addressed one answers as told, all others drive noise every cycle.
    task automatic drive_slaves(input logic [2:0] sel, input bit want, input logic slverr,
                                input logic [31:0] prd);
        apb.pready  = 6'($urandom);
        apb.pslverr = 6'($urandom);
        for (int i = 0; i < NS; i++) apb.prdata[i*RW +: RW] = $urandom;
        if (sel < 3'd6) begin
            apb.pready[sel]              = want;
            apb.pslverr[sel]             = slverr;
            apb.prdata[int'(sel)*RW +: RW] = prd;
        end
    endtask

    // Reference: the result of one command from the rules of the protocol alone.
    function automatic void model(input vec_t v, output logic [31:0] rdata, output logic err,
                                  output logic tmo, output int acc, output int lat);
        if (v.sel >= 3'd6) begin
            rdata = '0; err = 1'b1; tmo = 1'b0; acc = 0; lat = 1;
        end else if (v.waits >= TMO) begin
            rdata = '0; err = 1'b1; tmo = 1'b1; acc = TMO; lat = 2 + TMO;
        end else begin
            acc = v.waits + 1;
            lat = 2 + acc;
            err = v.slverr;
            tmo = 1'b0;
            rdata = v.wr ? 32'h0 : v.prd;
        end
    endfunction

    task automatic run_cmd(input vec_t v, output res_t r);
        logic [5:0]  exp_sel;
        logic [3:0]  exp_strb;
        logic [34:0] snap;
        bit          done;
        bit          want;
        int          k;
        exp_sel  = (v.sel < 3'd6) ? (6'b1 << v.sel) : 6'b0;
        exp_strb = v.wr ? v.strb : 4'h0;
        r = '{rdata: 32'h0, err: 1'b0, tmo: 1'b0, acc: 0, setup: 0, lat: -1, bad: 0};
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b1;
        cmd_write = v.wr;  cmd_sel  = v.sel;  cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
        drive_slaves(v.sel, 1'b0, v.slverr, v.prd);
        @(posedge clk);
        done = 1'b0;
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom); cmd_sel  = 3'($urandom); cmd_addr = 7'($urandom);
                cmd_wdata = $urandom;     cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
            end
            if (cmd_ready !== 1'b0) r.bad++;
            if (rsp_valid === 1'b1) begin
                done    = 1'b1;
                r.lat   = cyc;
                r.rdata = rsp_rdata;
                r.err   = rsp_err;
                r.tmo   = rsp_timeout;
                if (apb.psel !== 6'b0 || apb.penable !== 1'b0) r.bad++;
            end else if (apb.psel !== 6'b0) begin
                if (apb.psel !== exp_sel || apb.paddr !== v.addr || apb.pwrite !== v.wr ||
                    apb.pwdata !== v.wdata || apb.pstrb !== exp_strb || apb.pprot !== v.prot)
                    r.bad++;
                if (apb.penable === 1'b1) r.acc++;
                else r.setup++;
            end else if (apb.penable !== 1'b0) begin
                r.bad++;
            end
            want = (apb.penable === 1'b1) && (r.acc > v.waits);
            drive_slaves(v.sel, want, v.slverr, v.prd);
        end
        if (done) begin
            snap = {rsp_valid, rsp_rdata, rsp_err, rsp_timeout};
            for (int i = 0; i < v.rdly; i++) begin
                @(negedge clk);
                if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== snap) r.bad++;
                if (apb.psel !== 6'b0 || cmd_ready !== 1'b0) r.bad++;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) r.bad++;
        end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic check_res(input string tag, input vec_t v, input res_t r,
                             input logic [31:0] erd, input logic eerr, input logic etmo,
                             input int eacc, input int elat);
        chk({tag, "_rdata"},   64'(r.rdata), 64'(erd));
        chk({tag, "_err"},     64'(r.err),   64'(eerr));
        chk({tag, "_timeout"}, 64'(r.tmo),   64'(etmo));
        chk({tag, "_access"},  64'(r.acc),   64'(eacc));
        chk({tag, "_setup"},   64'(r.setup), (v.sel < 3'd6) ? 64'd1 : 64'd0);
        chk({tag, "_latency"}, 64'(r.lat),   64'(elat));
        chk({tag, "_protocol"}, 64'(r.bad),  64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t        v;
        res_t        r;
        logic [31:0] m_rd;
        logic        m_err, m_tmo;
        int          m_acc, m_lat;
        logic        pen_seen;
        int          k;
        int          wt_tab[8];

        wt_tab = '{0, 1, 2, 3, 14, 15, 16, 99};
        //            wr    sel   addr    wdata          strb  prot  wt  serr  prdata        rdly  e_rdata        e_err e_tmo acc lat
        vecs[0] = '{1'b1, 3'd3, 7'h10, 32'hDEADBEEF, 4'hF, 3'd0,  0, 1'b0, 32'hCAFEF00D, 0, 32'h00000000, 1'b0, 1'b0,  1,  3};
        vecs[1] = '{1'b0, 3'd5, 7'h04, 32'h00000000, 4'hF, 3'd2,  3, 1'b0, 32'h12345678, 1, 32'h12345678, 1'b0, 1'b0,  4,  6};
        vecs[2] = '{1'b0, 3'd2, 7'h08, 32'h00000000, 4'h0, 3'd1,  0, 1'b1, 32'h12345678, 0, 32'h12345678, 1'b1, 1'b0,  1,  3};
        vecs[3] = '{1'b0, 3'd1, 7'h20, 32'h00000000, 4'h0, 3'd0, 99, 1'b0, 32'hAAAA5555, 0, 32'h00000000, 1'b1, 1'b1, 16, 18};
        vecs[4] = '{1'b0, 3'd7, 7'h7F, 32'h00000000, 4'h0, 3'd0,  0, 1'b0, 32'h11111111, 5, 32'h00000000, 1'b1, 1'b0,  0,  1};
        vecs[5] = '{1'b1, 3'd0, 7'h3C, 32'h0BADF00D, 4'h5, 3'd3, 15, 1'b0, 32'h22222222, 2, 32'h00000000, 1'b0, 1'b0, 16, 18};
        vecs[6] = '{1'b0, 3'd4, 7'h44, 32'h00000000, 4'hA, 3'd7, 15, 1'b0, 32'h89ABCDEF, 0, 32'h89ABCDEF, 1'b0, 1'b0, 16, 18};
        vecs[7] = '{1'b1, 3'd6, 7'h01, 32'h00000001, 4'h1, 3'd0,  0, 1'b0, 32'h00000000, 3, 32'h00000000, 1'b1, 1'b0,  0,  1};
        vecs[8] = '{1'b1, 3'd2, 7'h55, 32'h5A5A5A5A, 4'hC, 3'd4,  2, 1'b1, 32'h33333333, 0, 32'h00000000, 1'b1, 1'b0,  3,  5};
        vecs[9] = '{1'b0, 3'd5, 7'h12, 32'h00000000, 4'h0, 3'd0, 16, 1'b0, 32'h44444444, 0, 32'h00000000, 1'b1, 1'b1, 16, 18};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_write = 1'b0; cmd_sel = '0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        drive_slaves(3'd0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_ctrl", 64'({rsp_valid, rsp_err, rsp_timeout, apb.psel, apb.penable, apb.pwrite}), 64'd0);
        chk("reset_fields", 64'({apb.pprot, apb.paddr, apb.pstrb}), 64'd0);
        chk("reset_data", {apb.pwdata, rsp_rdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i], r);
            check_res($sformatf("vec%0d", i), vecs[i], r, vecs[i].e_rdata, vecs[i].e_err,
                      vecs[i].e_tmo, vecs[i].e_acc, vecs[i].e_lat);
        end

        // Reset while a transfer sits in ACCESS (sel 1 never answers).
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 3'd1; cmd_addr = 7'h2A;
        cmd_wdata = 32'h0; cmd_strb = 4'h0; cmd_prot = 3'd0;
        drive_slaves(3'd1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (apb.penable !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        pen_seen = apb.penable;
        chk("rstmid_in_access", 64'(pen_seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_psel", 64'(apb.psel), 64'd0);
        chk("rstmid_penable", 64'(apb.penable), 64'd0);
        chk("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_paddr", 64'(apb.paddr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        v = '{1'b0, 3'd4, 7'h30, 32'h0, 4'h0, 3'd5, 1, 1'b0, 32'hFEEDFACE, 0,
              32'hFEEDFACE, 1'b0, 1'b0, 2, 4};
        run_cmd(v, r);
        check_res("after_rst", v, r, v.e_rdata, v.e_err, v.e_tmo, v.e_acc, v.e_lat);

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.wr     = 1'($urandom);
            v.sel    = 3'($urandom_range(0, 7));
            v.addr   = 7'($urandom);
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.waits  = wt_tab[$urandom_range(0, 7)];
            v.slverr = 1'($urandom);
            v.prd    = $urandom;
            v.rdly   = $urandom_range(0, 3);
            model(v, m_rd, m_err, m_tmo, m_acc, m_lat);
            run_cmd(v, r);
            check_res($sformatf("rnd%0d", n), v, r, m_rd, m_err, m_tmo, m_acc, m_lat);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
